// File: rtl/vga_bus_interface.sv
// Processor-bus register window feeding the VGA frame buffer's port A and
// colour config, with a whole-buffer hardware fill engine.
module vga_bus_interface #(
    parameter logic [7:0]  BASE_ADDR     = 8'hB0,
    parameter int unsigned FB_DEPTH_LOG2 = 15
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [7:0]               BUS_ADDR,
    inout  wire  [7:0]               BUS_DATA,
    input  logic                     BUS_WE,
    output logic                     FB_WE,
    output logic [FB_DEPTH_LOG2-1:0] FB_ADDR,
    output logic                     FB_DATA,
    output logic [15:0]              CONFIG_COLOURS,
    output logic                     BUSY
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [FB_DEPTH_LOG2-1:0] CNT_ONE = 1;

    state_t                   state_q, state_d;
    logic [7:0]               x_q, x_d;
    logic [6:0]               y_q, y_d;
    logic [FB_DEPTH_LOG2-1:0] cnt_q, cnt_d;
    logic                     fill_val_q, fill_val_d;
    logic [15:0]              colours_q, colours_d;
    logic                     fb_we_q, fb_we_d;
    logic [FB_DEPTH_LOG2-1:0] fb_addr_q, fb_addr_d;
    logic                     fb_data_q, fb_data_d;

    logic [7:0] offset;
    logic       in_win;
    logic       wr_x, wr_y, wr_pix, wr_col_lo, wr_col_hi, wr_fill;
    logic       rd_status;

    assign offset    = BUS_ADDR - BASE_ADDR;
    assign in_win    = (offset < 8'd6);
    assign wr_x      = BUS_WE && in_win && (offset == 8'd0);
    assign wr_y      = BUS_WE && in_win && (offset == 8'd1);
    assign wr_pix    = BUS_WE && in_win && (offset == 8'd2);
    assign wr_col_lo = BUS_WE && in_win && (offset == 8'd3);
    assign wr_col_hi = BUS_WE && in_win && (offset == 8'd4);
    assign wr_fill   = BUS_WE && in_win && (offset == 8'd5);
    assign rd_status = !BUS_WE && (offset == 8'd5);

    assign BUS_DATA = rd_status ? {7'b0, BUSY} : 8'bz;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            cnt_q      <= '0;
            fill_val_q <= 1'b0;
            colours_q  <= 16'h00FF;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cnt_q      <= cnt_d;
            fill_val_q <= fill_val_d;
            colours_q  <= colours_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        cnt_d      = cnt_q;
        fill_val_d = fill_val_q;
        colours_d  = colours_q;
        fb_we_d    = 1'b0;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;

        unique case (state_q)
            IDLE: begin
                if (wr_fill) begin
                    // Address 0 is written on the starting edge so BUSY and the
                    // first strobe appear together; the counter runs one ahead.
                    state_d    = FILL;
                    fill_val_d = BUS_DATA[0];
                    fb_we_d    = 1'b1;
                    fb_addr_d  = '0;
                    fb_data_d  = BUS_DATA[0];
                    cnt_d      = CNT_ONE;
                end else if (wr_pix) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = {y_q, x_q};
                    fb_data_d = BUS_DATA[0];
                    x_d       = x_q + 8'd1;
                    if (x_q == 8'hFF) begin
                        y_d = y_q + 7'd1;
                    end
                end
            end
            FILL: begin
                // Counter wrapping back to 0 marks the cycle after the final write.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = cnt_q;
                    fb_data_d = fill_val_q;
                    cnt_d     = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_x) begin
            x_d = BUS_DATA;
        end
        if (wr_y) begin
            y_d = BUS_DATA[6:0];
        end
        if (wr_col_lo) begin
            colours_d[7:0] = BUS_DATA;
        end
        if (wr_col_hi) begin
            colours_d[15:8] = BUS_DATA;
        end
    end

    assign FB_WE          = fb_we_q;
    assign FB_ADDR        = fb_addr_q;
    assign FB_DATA        = fb_data_q;
    assign CONFIG_COLOURS = colours_q;
    assign BUSY           = (state_q == FILL);

endmodule

// File: tb/tb_vga_bus_interface.sv
// Directed plus randomized bench for vga_bus_interface against an arithmetic
// reference model of the register window, pixel writes and fill timing.
module tb_vga_bus_interface;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  BUS_ADDR;
    logic        BUS_WE;
    logic [7:0]  drv_data;
    logic        drv_en;
    wire  [7:0]  BUS_DATA;
    logic        FB_WE;
    logic [14:0] FB_ADDR;
    logic        FB_DATA;
    logic [15:0] CONFIG_COLOURS;
    logic        BUSY;

    assign BUS_DATA = drv_en ? drv_data : 8'bz;

    always #10 CLK = ~CLK;

    vga_bus_interface #(
        .BASE_ADDR    (8'hB0),
        .FB_DEPTH_LOG2(15)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .BUS_ADDR      (BUS_ADDR),
        .BUS_DATA      (BUS_DATA),
        .BUS_WE        (BUS_WE),
        .FB_WE         (FB_WE),
        .FB_ADDR       (FB_ADDR),
        .FB_DATA       (FB_DATA),
        .CONFIG_COLOURS(CONFIG_COLOURS),
        .BUSY          (BUSY)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: pixel cursor, colours, and fill as a start-cycle stamp.
    int          m_x, m_y;
    int          m_last_addr, m_last_data, m_we, m_fill_val;
    logic [15:0] m_col;
    bit          m_fill;
    longint      m_start;
    longint      cyc = 0;
    int          we_count;

    function automatic bit model_busy();
        return m_fill && ((cyc - m_start) <= 64'd32767);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst_n, input logic [7:0] a, input logic we, input logic [7:0] d);
        bit busy_before;
        int off;
        RESET    = rst_n;
        BUS_ADDR = a;
        BUS_WE   = we;
        drv_en   = we;
        drv_data = d;
        busy_before = model_busy();
        #1;
        if (!we && a == 8'hB5) begin
            check("status_rd", {24'b0, BUS_DATA}, {31'b0, busy_before});
        end
        @(posedge CLK);
        #1;
        cyc++;
        m_we = 0;
        if (!rst_n) begin
            m_x = 0; m_y = 0; m_fill = 0; m_col = 16'h00FF;
            m_last_addr = 0; m_last_data = 0;
        end else begin
            off = int'(a) - 'hB0;
            if (we && off >= 0 && off <= 5) begin
                case (off)
                    0: m_x = int'(d);
                    1: m_y = int'(d) % 128;
                    2: if (!busy_before) begin
                        m_we = 1;
                        m_last_addr = m_y * 256 + m_x;
                        m_last_data = int'(d) % 2;
                        m_x = m_x + 1;
                        if (m_x == 256) begin
                            m_x = 0;
                            m_y = (m_y + 1) % 128;
                        end
                    end
                    3: m_col[7:0]  = d;
                    4: m_col[15:8] = d;
                    5: if (!busy_before) begin
                        m_fill = 1;
                        m_start = cyc;
                        m_fill_val = int'(d) % 2;
                    end
                    default: ;
                endcase
            end
            if (model_busy()) begin
                m_we = 1;
                m_last_addr = int'(cyc - m_start);
                m_last_data = m_fill_val;
            end
        end
        if (FB_WE === 1'b1) we_count++;
        check("fb_we",   {31'b0, FB_WE},   m_we);
        check("fb_addr", {17'b0, FB_ADDR}, m_last_addr);
        check("fb_data", {31'b0, FB_DATA}, m_last_data);
        check("busy",    {31'b0, BUSY},    {31'b0, model_busy()});
        check("colours", {16'b0, CONFIG_COLOURS}, {16'b0, m_col});
    endtask

    task automatic idle();
        step(1'b1, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        int k;
        logic [7:0] ra, rd;
        m_x = 0; m_y = 0; m_fill = 0; m_col = 16'h00FF;
        m_last_addr = 0; m_last_data = 0; m_we = 0; m_fill_val = 0; m_start = 0;
        we_count = 0;
        RESET = 1'b0; BUS_ADDR = 8'h00; BUS_WE = 1'b0; drv_en = 1'b0; drv_data = 8'h00;

        // Reset state
        step(1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b0, 8'h00);
        check("rst_colours", {16'b0, CONFIG_COLOURS}, 32'h00FF);
        check("rst_busy",    {31'b0, BUSY},  0);
        check("rst_fb_we",   {31'b0, FB_WE}, 0);
        check("rst_fb_addr", {17'b0, FB_ADDR}, 0);

        // Single pixel writes
        step(1'b1, 8'hB0, 1'b1, 8'h10);
        step(1'b1, 8'hB1, 1'b1, 8'h05);
        step(1'b1, 8'hB2, 1'b1, 8'h01);
        check("pix1_addr", {17'b0, FB_ADDR}, 32'h0510);
        check("pix1_data", {31'b0, FB_DATA}, 1);
        idle();
        check("pix1_pulse", {31'b0, FB_WE}, 0);
        step(1'b1, 8'hB2, 1'b1, 8'h00);
        check("pix2_addr", {17'b0, FB_ADDR}, 32'h0511);
        check("pix2_data", {31'b0, FB_DATA}, 0);

        // X and Y wrap with back-to-back writes
        step(1'b1, 8'hB0, 1'b1, 8'hFF);
        step(1'b1, 8'hB1, 1'b1, 8'h7F);
        step(1'b1, 8'hB2, 1'b1, 8'h01);
        check("wrap1_addr", {17'b0, FB_ADDR}, 32'h7FFF);
        step(1'b1, 8'hB2, 1'b1, 8'h01);
        check("wrap2_addr", {17'b0, FB_ADDR}, 32'h0000);
        check("wrap2_we",   {31'b0, FB_WE}, 1);

        // Fill with 1, with bus traffic during the fill
        we_count = 0;
        step(1'b1, 8'hB5, 1'b1, 8'h01);
        k = 0;
        while (BUSY === 1'b1 && k < 40000) begin
            k++;
            case (k)
                100: step(1'b1, 8'hB5, 1'b0, 8'h00);
                200: step(1'b1, 8'hB2, 1'b1, 8'h01);
                300: step(1'b1, 8'hB5, 1'b1, 8'h00);
                400: begin
                    step(1'b1, 8'hB3, 1'b1, 8'h1C);
                    check("col_in_fill", {24'b0, CONFIG_COLOURS[7:0]}, 32'h1C);
                end
                default: idle();
            endcase
        end
        check("fill_we_count", we_count, 32768);
        check("fill_cycles",   k, 32768);
        step(1'b1, 8'hB5, 1'b0, 8'h00);
        // Cursor must still be at (1,0): the in-fill pixel write was dropped
        step(1'b1, 8'hB2, 1'b1, 8'h01);
        check("post_fill_addr", {17'b0, FB_ADDR}, 32'h0001);

        // Randomized register traffic
        for (int i = 0; i < 400; i++) begin
            rd = 8'($urandom);
            case ($urandom_range(0, 9))
                0: step(1'b1, 8'hB0, 1'b1, ($urandom_range(0, 3) == 0) ? 8'hFE : rd);
                1: step(1'b1, 8'hB1, 1'b1, ($urandom_range(0, 3) == 0) ? 8'hFF : rd);
                2, 3, 4: step(1'b1, 8'hB2, 1'b1, rd);
                5: step(1'b1, 8'hB3, 1'b1, rd);
                6: step(1'b1, 8'hB4, 1'b1, rd);
                7: step(1'b1, 8'hB5, 1'b0, rd);
                8: begin
                    ra = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 8'hAF))
                                                     : 8'($urandom_range(8'hB6, 8'hFF));
                    step(1'b1, ra, 1'b1, rd);
                end
                default: idle();
            endcase
        end

        // Fill with 0, reset at counter 1000
        step(1'b1, 8'hB5, 1'b1, 8'h00);
        for (int i = 0; i < 1000; i++) idle();
        check("pre_rst_addr", {17'b0, FB_ADDR}, 1000);
        step(1'b0, 8'h00, 1'b0, 8'h00);
        check("midfill_rst_we",   {31'b0, FB_WE}, 0);
        check("midfill_rst_busy", {31'b0, BUSY},  0);
        we_count = 0;
        for (int i = 0; i < 8; i++) idle();
        check("post_rst_no_we", we_count, 0);
        step(1'b1, 8'hB5, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
